// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter and every requester that drives the I2C master core:
// core register map, control-register command bytes and arbiter state encodings.
package i2c_bus_arbiter_pkg;

  localparam int IDX_W = 2;

  localparam logic [2:0] PRER_LO_ADR = 3'd0;
  localparam logic [2:0] PRER_HI_ADR = 3'd1;
  localparam logic [2:0] CTR_ADR     = 3'd2;
  localparam logic [2:0] TXR_ADR     = 3'd3;
  localparam logic [2:0] RXR_ADR     = 3'd3;
  localparam logic [2:0] CR_ADR      = 3'd4;
  localparam logic [2:0] SR_ADR      = 3'd4;

  localparam logic [7:0] CR_START_WRITE = 8'h90;
  localparam logic [7:0] CR_WRITE       = 8'h10;
  localparam logic [7:0] CR_STOP_WRITE  = 8'h50;
  localparam logic [7:0] CR_READ_NACK   = 8'h28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and core-side wishbone signals of the arbiter. Handshake: stb is a held
// request that may only drop after ack; ack completes exactly one transfer; cyc frames a transaction.
interface i2c_bus_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   i_req_cyc;
  logic [N_REQ-1:0]   i_req_stb;
  logic [N_REQ-1:0]   i_req_we;
  logic [3*N_REQ-1:0] i_req_adr;
  logic [8*N_REQ-1:0] i_req_dat;
  logic [7:0]         o_req_dat;
  logic [N_REQ-1:0]   o_req_ack;
  logic [N_REQ-1:0]   o_grant;
  logic [2:0]         o_wbs_adr;
  logic [7:0]         o_wbs_dat;
  logic               o_wbs_we;
  logic               o_wbs_stb;
  logic               o_wbs_cyc;
  logic [7:0]         i_wbs_dat;
  logic               i_wbs_ack;
  logic               o_timeout;
  logic [1:0]         o_timeout_id;

  modport slave (
    input  i_req_cyc, i_req_stb, i_req_we, i_req_adr, i_req_dat, i_wbs_dat, i_wbs_ack,
    output o_req_dat, o_req_ack, o_grant, o_wbs_adr, o_wbs_dat, o_wbs_we, o_wbs_stb,
           o_wbs_cyc, o_timeout, o_timeout_id
  );

  modport master (
    output i_req_cyc, i_req_stb, i_req_we, i_req_adr, i_req_dat, i_wbs_dat, i_wbs_ack,
    input  o_req_dat, o_req_ack, o_grant, o_wbs_adr, o_wbs_dat, o_wbs_we, o_wbs_stb,
           o_wbs_cyc, o_timeout, o_timeout_id
  );

endinterface

// File: rtl/i2c_bus_arbiter_rr_arbiter_pick.sv
// Combinational round-robin picker: the first unmasked requester after i_last wins,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(i_last) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!o_any && i_req[idx] && !i_mask[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_idx        = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master core between N_REQ wishbone requesters, one whole transaction at a
// time, with round-robin fairness, a hold-time limit and a drain of any abandoned strobe.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int MAX_HOLD_CYC = 2_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  i2c_bus_arbiter_if.slave    bus,
  output arb_state_e          o_state
);

  localparam int              CNT_W     = $clog2(MAX_HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD_CYC - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_winner_q, last_winner_d;
  logic [IDX_W-1:0] timeout_id_q, timeout_id_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       last_adr_q, last_adr_d;
  logic [7:0]       last_dat_q, last_dat_d;
  logic             last_we_q, last_we_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             own_cyc, own_stb, own_we;
  logic [2:0]       own_adr;
  logic [7:0]       own_dat;
  logic             outstanding;

  rr_arbiter_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (bus.i_req_cyc),
    .i_mask  (mask_q),
    .i_last  (last_winner_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_cyc = bus.i_req_cyc[k];
        own_stb = bus.i_req_stb[k];
        own_we  = bus.i_req_we[k];
        own_adr = bus.i_req_adr[3*k +: 3];
        own_dat = bus.i_req_dat[8*k +: 8];
      end
    end
  end

  // Core-facing port and acks: owner mirrored in OWNED, latched request replayed in DRAIN.
  always_comb begin
    bus.o_wbs_cyc = 1'b0;
    bus.o_wbs_stb = 1'b0;
    bus.o_wbs_we  = 1'b0;
    bus.o_wbs_adr = '0;
    bus.o_wbs_dat = '0;
    bus.o_req_ack = '0;
    bus.o_req_dat = '0;
    case (state_q)
      ST_OWNED: begin
        bus.o_wbs_cyc = 1'b1;
        bus.o_wbs_stb = own_stb;
        bus.o_wbs_we  = own_we;
        bus.o_wbs_adr = own_adr;
        bus.o_wbs_dat = own_dat;
        bus.o_req_ack = grant_q & {N_REQ{bus.i_wbs_ack & own_stb}};
        bus.o_req_dat = bus.i_wbs_dat;
      end
      ST_DRAIN: begin
        bus.o_wbs_cyc = 1'b1;
        bus.o_wbs_stb = 1'b1;
        bus.o_wbs_we  = last_we_q;
        bus.o_wbs_adr = last_adr_q;
        bus.o_wbs_dat = last_dat_q;
      end
      default: ;
    endcase
  end

  assign bus.o_grant      = grant_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_timeout_id = timeout_id_q;
  assign o_state          = state_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    hold_cnt_d    = hold_cnt_q;
    mask_d        = mask_q & bus.i_req_cyc;
    timeout_d     = 1'b0;
    timeout_id_d  = timeout_id_q;
    last_adr_d    = last_adr_q;
    last_dat_d    = last_dat_q;
    last_we_d     = last_we_q;
    outstanding   = own_stb & ~bus.i_wbs_ack;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d       = ST_OWNED;
          grant_d       = pick_grant;
          owner_d       = pick_idx;
          last_winner_d = pick_idx;
          hold_cnt_d    = '0;
        end
      end
      ST_OWNED: begin
        last_adr_d = own_adr;
        last_dat_d = own_dat;
        last_we_d  = own_we;
        if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
        if (!own_cyc) begin
          grant_d = '0;
          state_d = outstanding ? ST_DRAIN : ST_IDLE;
        end else if (hold_cnt_q >= HOLD_LAST) begin
          // Forced release: the owner stays locked out until it drops cyc once.
          grant_d      = '0;
          timeout_d    = 1'b1;
          timeout_id_d = owner_q;
          mask_d       = mask_d | grant_q;
          state_d      = outstanding ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.i_wbs_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      mask_q        <= '0;
      owner_q       <= '0;
      last_winner_q <= IDX_W'(N_REQ - 1);
      timeout_id_q  <= '0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
      last_adr_q    <= '0;
      last_dat_q    <= '0;
      last_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      mask_q        <= mask_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      timeout_id_q  <= timeout_id_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
      last_adr_q    <= last_adr_d;
      last_dat_q    <= last_dat_d;
      last_we_q     <= last_we_d;
    end
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of requesters (range 2..4).
REQ-002 The block SHALL have parameter MAX_HOLD_CYC, default 2_000_000, meaning the maximum number of cycles one owner may hold the bus.
REQ-003 i_clk  in  1  clock; reset i_reset, synchronous, active-high; clock i_clk.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_req_cyc  in  N_REQ  per-requester bus lock, held high for one whole I2C transaction (START..STOP).
REQ-006 i_req_stb  in  N_REQ  per-requester wishbone strobe.
REQ-007 i_req_we  in  N_REQ  per-requester write enable.
REQ-008 i_req_adr  in  3*N_REQ  flattened register addresses; requester k uses bits [3k+2:3k].
REQ-009 i_req_dat  in  8*N_REQ  flattened write data; requester k uses bits [8k+7:8k].
REQ-010 o_req_dat  out  8  read data, broadcast to all requesters.
REQ-011 o_req_ack  out  N_REQ  per-requester ack; only the owner's bit may be asserted.
REQ-012 o_grant  out  N_REQ  one-hot owner indication; all zero when the bus is unowned.
REQ-013 o_wbs_adr/o_wbs_dat/o_wbs_we/o_wbs_stb/o_wbs_cyc  out  3/8/1/1/1  wishbone master port to the I2C master core.
REQ-014 i_wbs_dat/i_wbs_ack  in  8/1  wishbone read data and ack from the I2C master core.
REQ-015 o_timeout  out  1  one-cycle pulse on a forced release; o_timeout_id  out  2  index of the requester that was released.

Function
REQ-016 The states SHALL be IDLE, OWNED and DRAIN.
REQ-017 In IDLE with any i_req_cyc bit high, the arbiter SHALL grant the first requesting index after last_winner (round-robin, wrapping N_REQ-1→0) and enter OWNED.
REQ-018 o_grant SHALL assert on the cycle after arbitration (one-cycle latency from i_req_cyc).
REQ-019 In OWNED, o_wbs_cyc SHALL be 1, and o_wbs_adr/dat/we/stb SHALL combinationally mirror the owner's fields.
REQ-020 In OWNED, i_wbs_ack SHALL route to o_req_ack[owner] only, with o_req_dat = i_wbs_dat.
REQ-021 Non-owner strobes SHALL be ignored and never acked; requesters hold stb until ack.
REQ-022 When the owner drops cyc with no strobe outstanding, the block SHALL enter IDLE next cycle with o_grant=0, giving one mandatory dead cycle before the next grant.
REQ-023 When the owner drops cyc while stb is outstanding and unacked, the block SHALL enter DRAIN.
REQ-024 In DRAIN, the block SHALL hold the last address/data/we with stb=cyc=1 until i_wbs_ack, suppress that ack, then go to IDLE.
REQ-025 A hold counter SHALL clear on grant and increment each OWNED cycle; at MAX_HOLD_CYC it SHALL force release: DRAIN if stb is outstanding, else IDLE.
REQ-026 A forced release SHALL pulse o_timeout and load o_timeout_id.
REQ-027 A timed-out requester SHALL be masked from arbitration until it deasserts its i_req_cyc for at least one cycle.
REQ-028 The hold counter SHALL saturate and never wrap.
REQ-029 When a release and new requests coincide, arbitration SHALL occur in the following IDLE cycle using the updated last_winner.
REQ-030 o_grant SHALL never be non-one-hot, and o_wbs_stb SHALL never assert while o_wbs_cyc=0.

Reset
REQ-031 On reset, state SHALL be IDLE, o_grant=0, o_req_ack=0, o_wbs_cyc=o_wbs_stb=o_wbs_we=0, o_wbs_adr=0, o_wbs_dat=0, o_timeout=0, o_timeout_id=0, the hold counter=0 and the timeout mask=0.
REQ-032 On reset, last_winner SHALL be N_REQ-1, so requester 0 wins first.
REQ-033 Reset mid-transaction SHALL abandon the transfer immediately with no drain; the I2C core is reset by the same i_reset.

Structure
REQ-034 A shared include header SHALL hold the I2C-core register addresses (PRER_LO, PRER_HI, CTR, TXR/RXR, CR/SR), the CR command bytes (0x90, 0x10, 0x50, 0x28) and the state encodings, for reuse by all requesters.
REQ-035 One sub-module rr_arbiter_pick (combinational round-robin picker: request vector, mask, last_winner → one-hot winner) SHALL be used.

Verification
REQ-036 After reset, requesters 0 and 2 raise cyc in the same cycle -> grant=001 next cycle; after 0 releases and one dead cycle, grant=100.
REQ-037 Owner 1 writes adr=4, dat=0x90 and the core acks after 2 cycles -> o_wbs_* mirror the owner, o_req_ack=010 for exactly 1 cycle, no other ack.
REQ-038 Non-owner 0 strobes during owner 1's transaction -> no o_wbs_stb change from requester 0, and o_req_ack[0] stays 0 throughout.
REQ-039 Owner drops cyc with stb pending and the ack arrives 3 cycles later -> DRAIN holds stb=1, the ack is not forwarded, then IDLE.
REQ-040 MAX_HOLD_CYC=50 and owner 2 holds cyc for 60 cycles -> o_timeout pulse at cycle 50 with id=2, and requester 2 is not regranted until it toggles cyc.
REQ-041 Reset asserted mid-strobe -> all outputs 0 next cycle, and the next grant goes to requester 0.
